// File: rtl/piso_pkg.sv
// Shared serializer/deserializer definitions: FSM state encoding common to both link ends.
package piso_pkg;

  localparam int unsigned STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } piso_state_e;

endpackage : piso_pkg

// File: rtl/piso_tx_if.sv
// Handshake and serial-output bundle for piso_tx; master drives words, slave serializes them.
interface piso_tx_if #(
  parameter int unsigned N = 4
);

  logic         valid;
  logic [N-1:0] parallel_in;
  logic         shift_en;
  logic         ready;
  logic         serial_out;
  logic         serial_valid;
  logic         done;

  modport master (
    output valid, parallel_in, shift_en,
    input  ready, serial_out, serial_valid, done
  );

  modport slave (
    input  valid, parallel_in, shift_en,
    output ready, serial_out, serial_valid, done
  );

endinterface : piso_tx_if

// File: rtl/piso_tx.sv
// Parallel-in serial-out transmitter: captures an N-bit word and emits it one bit per
// enabled cycle, MSB or LSB first, followed by a one-cycle done pulse.
module piso_tx
  import piso_pkg::*;
#(
  parameter int unsigned N         = 4,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_valid,
  input  logic [N-1:0] i_parallel_in,
  input  logic         i_shift_en,
  output logic         o_ready,
  output logic         o_serial_out,
  output logic         o_serial_valid,
  output logic         o_done
);

  localparam int unsigned CW   = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  piso_state_e  r_state, w_state_nxt;
  logic [N-1:0] r_sreg, w_sreg_nxt;
  logic [CW-1:0] r_cnt, w_cnt_nxt;

  logic r_ready, w_ready_nxt;
  logic r_serial_out, w_serial_out_nxt;
  logic r_serial_valid, w_serial_valid_nxt;
  logic r_done, w_done_nxt;

  // Bit currently sitting at the output end of the shift register.
  function automatic logic out_bit(input logic [N-1:0] s);
    return MSB_FIRST ? s[N-1] : s[0];
  endfunction

  function automatic logic [N-1:0] shift_toward_out(input logic [N-1:0] s);
    return MSB_FIRST ? {s[N-2:0], 1'b0} : {1'b0, s[N-1:1]};
  endfunction

  // Next-state and next-output decode; outputs are registered from the next state.
  always_comb begin
    w_state_nxt        = r_state;
    w_sreg_nxt         = r_sreg;
    w_cnt_nxt          = r_cnt;
    w_ready_nxt        = 1'b0;
    w_serial_out_nxt   = 1'b0;
    w_serial_valid_nxt = 1'b0;
    w_done_nxt         = 1'b0;

    unique case (r_state)
      IDLE: begin
        if (i_valid) begin
          w_sreg_nxt  = i_parallel_in;
          w_cnt_nxt   = '0;
          w_state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        if (i_shift_en) begin
          w_sreg_nxt = shift_toward_out(r_sreg);
          w_cnt_nxt  = r_cnt + CW'(1);
          if (r_cnt == LAST) w_state_nxt = DONE;
        end
      end
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase

    w_ready_nxt        = (w_state_nxt == IDLE);
    w_serial_valid_nxt = (w_state_nxt == SHIFT);
    w_done_nxt         = (w_state_nxt == DONE);
    w_serial_out_nxt   = w_serial_valid_nxt ? out_bit(w_sreg_nxt) : 1'b0;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state        <= IDLE;
      r_sreg         <= '0;
      r_cnt          <= '0;
      r_ready        <= 1'b1;
      r_serial_out   <= 1'b0;
      r_serial_valid <= 1'b0;
      r_done         <= 1'b0;
    end else begin
      r_state        <= w_state_nxt;
      r_sreg         <= w_sreg_nxt;
      r_cnt          <= w_cnt_nxt;
      r_ready        <= w_ready_nxt;
      r_serial_out   <= w_serial_out_nxt;
      r_serial_valid <= w_serial_valid_nxt;
      r_done         <= w_done_nxt;
    end
  end

  assign o_ready        = r_ready;
  assign o_serial_out   = r_serial_out;
  assign o_serial_valid = r_serial_valid;
  assign o_done         = r_done;

endmodule : piso_tx
